// File: rtl/ip_tracker.sv
// ip_tracker: fetch instruction-pointer register plus a FIFO of start
// addresses for every started-but-uncommitted instruction. A rollback
// restores the IP to the oldest uncommitted start address and flushes
// the FIFO. All outputs are registered or read straight from registered
// storage, so there is no combinational input-to-output path.
//
// Handshake: there is no valid/ready handshake. Every control input is a
// single-cycle request that is honoured unconditionally on the rising edge
// where it is high. A push against a full FIFO is dropped and reported
// through the sticky overflow flag. A commit against an empty FIFO is
// ignored and reported through the sticky underflow flag.
module ip_tracker #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int MAX_INC = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start_instruction,
    input  logic                           commit,
    input  logic                           rollback,
    input  logic                           inc,
    input  logic [$clog2(MAX_INC+1)-1:0]   inc_amount,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_val,
    output logic [WIDTH-1:0]               val,
    output logic [WIDTH-1:0]               head_val,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty,
    output logic                           full,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Same-cycle events are resolved in order: commit, then rollback, then push.
    logic             commit_ok;
    logic [PW-1:0]    rd_post;
    logic [CW-1:0]    cnt_post;
    logic             target_ok;
    logic [WIDTH-1:0] target;
    logic [CW-1:0]    cnt_flush;
    logic [PW-1:0]    rd_flush;
    logic             push_ok;
    logic             push_drop;
    logic [WIDTH-1:0] push_val;
    logic [WIDTH-1:0] val_next;
    logic [CW-1:0]    cnt_next;

    // Next-state resolution of the FIFO pointers, count and fetch IP.
    always_comb begin
        commit_ok = commit && (count != '0);
        rd_post   = rd_ptr + PW'(commit_ok);
        cnt_post  = count - CW'(commit_ok);
        // The rollback target is whatever is at the head once the commit is applied.
        target    = mem[rd_post];
        target_ok = rollback && (cnt_post != '0);
        // A flush empties the FIFO by moving the read pointer onto the tail.
        cnt_flush = rollback ? '0 : cnt_post;
        rd_flush  = rollback ? wr_ptr : rd_post;
        push_ok   = start_instruction && (cnt_flush != CW'(DEPTH));
        push_drop = start_instruction && !push_ok;
        // The pushed address is the IP at which the new instruction begins.
        push_val  = wr_en ? wr_val : (target_ok ? target : val);
        cnt_next  = cnt_flush + CW'(push_ok);
        if (wr_en)
            val_next = wr_val;
        else if (target_ok)
            val_next = target;
        else if (inc)
            val_next = val + WIDTH'(inc_amount);
        else
            val_next = val;
    end

    // Control state: IP, pointers, count, status flags and sticky errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            val       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            val    <= val_next;
            rd_ptr <= rd_flush;
            wr_ptr <= wr_ptr + PW'(push_ok);
            count  <= cnt_next;
            empty  <= (cnt_next == '0);
            full   <= (cnt_next == CW'(DEPTH));
            if (push_drop)
                overflow <= 1'b1;
            if (commit && !commit_ok)
                underflow <= 1'b1;
        end
    end

    // Address storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_val;
    end

    assign head_val = empty ? '0 : mem[rd_ptr];

endmodule
